music_play_ctrl: RTL and testbench
==================================

Name: music_play_ctrl

Overview:
Playback sequencer for the buzzer music path. It walks a song ROM note by note and decodes each 6-bit note code into a duration. For every note it drives a silent gap followed by a sounding phase, and it feeds the note code and a gate to the downstream tone generator. It also handles play/pause/stop/next/prev/loop user control and sits between the button debouncers, the song ROM and the PWM tone generator.

Parameters:
UNIT_CYCLES, 12_500_000, clk cycles per sixteenth-note unit (0.125 s at 100 MHz)
GAP_CYCLES, 2_500_000, silent clk cycles per unit at the start of each note (must be < UNIT_CYCLES)
NUM_SONGS, 3, number of selectable songs
IDX_W, 8, note index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
play  in  1  one-cycle pulse: start or resume
pause  in  1  one-cycle pulse: freeze playback
stop  in  1  one-cycle pulse: abort, rewind to note 0
next  in  1  one-cycle pulse: select next song
prev  in  1  one-cycle pulse: select previous song
loop_en  in  1  level: restart the song at its end
song_len  in  IDX_W  note count of the selected song (from ROM)
rom_code  in  6  note code at rom_addr, valid 1 cycle after rom_addr
song_sel  out  2  selected song, 0..NUM_SONGS-1
rom_addr  out  IDX_W  current note index (registered)
tone_code  out  6  latched note code for the tone generator
tone_gate  out  1  1 = tone generator sounds
busy  out  1  1 in any state except IDLE
song_done  out  1  one-cycle pulse when the last note completes

Behaviour:
- Reset (async, any time, including mid-note): state IDLE; song_sel=0, rom_addr=0, tone_code=0, tone_gate=0, busy=0, song_done=0; timers cleared.
- States: IDLE, ADDR, LOAD, GAP, SOUND, PAUSED.
- Duration units u, decoded from the code: 0-7, 22-28, 43-49 -> u=2; 8-14, 29-35, 50-56 -> u=4; 15-21, 36-42, 57-63 -> u=1. Code 0 is a rest.
- Timing per note: gap = u*GAP_CYCLES cycles, sound = u*(UNIT_CYCLES-GAP_CYCLES) cycles. Timer is 32 bits, unsigned, and compares against the target minus 1.
- IDLE: play -> ADDR. Index is unchanged, and is 0 after stop or reset.
- ADDR (1 cycle):
  - If rom_addr >= song_len, the song ends: song_done=1 for that cycle; rom_addr<=0; next state is ADDR if loop_en, else IDLE.
  - Otherwise -> LOAD.
- LOAD (1 cycle): tone_code<=rom_code, latch u -> GAP.
- GAP: tone_gate=0; after gap cycles -> SOUND.
- SOUND: tone_gate=1 unless tone_code==0. After sound cycles: tone_gate=0, rom_addr<=rom_addr+1 -> ADDR.
- Fetch overhead is 2 cycles per note (ADDR+LOAD); tone_gate is 0 during it.
- pause in ADDR/LOAD/GAP/SOUND -> PAUSED. The timer, rom_addr and the return state are saved; tone_gate=0.
- play in PAUSED returns to the saved state with the timer continuing from its frozen value.
- Control priority within a cycle: rst > stop > next/prev > pause > play.
  - stop in any state -> IDLE, rom_addr=0, tone_gate=0; no song_done pulse.
  - next: song_sel = (song_sel+1) mod NUM_SONGS. prev: song_sel = (song_sel+NUM_SONGS-1) mod NUM_SONGS.
  - After next or prev: rom_addr=0 and the timer is cleared. From ADDR/LOAD/GAP/SOUND -> ADDR; from IDLE or PAUSED -> IDLE.
  - next and prev asserted in the same cycle are both ignored.
  - play while already playing is ignored; pause in IDLE is ignored.
- song_len==0: play gives an immediate song_done in the first ADDR cycle, then IDLE (or a continuous done every ADDR cycle if loop_en; this case is allowed).
- loop_en is sampled only in the end-of-song ADDR cycle.
- rom_addr wraps only through the end check and never exceeds song_len.

Test Plan:
UNIT_CYCLES=8, GAP_CYCLES=2, song0 len=2, codes {8,15}; play -> 2 fetch cycles, gate 0 for 8 cycles, gate 1 for 24 cycles, 2 fetch cycles, gate 0 for 2 cycles, gate 1 for 6 cycles, then song_done pulse, busy=0, rom_addr=0.
Rest note: code 0 -> gate stays 0 for all 2*8=16 timed cycles, tone_code=0, index advances.
pause on the 10th SOUND cycle, hold 50 cycles, then play -> gate resumes and stays 1 for exactly 14 more cycles before ADDR.
loop_en=1 with song len=2 -> song_done pulses at end, playback restarts at rom_addr=0 with no IDLE cycle; stop mid-GAP -> IDLE, gate 0, no song_done.
next at song_sel=2 -> song_sel=0, rom_addr=0, re-fetch; prev at song_sel=0 -> song_sel=2; next+prev in the same cycle -> no change.
rst asserted asynchronously mid-SOUND -> tone_gate drops immediately without a clock edge; all outputs at reset values; after release, play starts song 0 from note 0.

Source files
------------

// File: rtl/music_play_ctrl.sv
// Buzzer playback sequencer: walks the song ROM, times the gap and sounding phase of each note,
// and handles play/pause/stop/next/prev/loop control.
module music_play_ctrl #(
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned NUM_SONGS   = 3,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             pause,
  input  logic             stop,
  input  logic             next,
  input  logic             prev,
  input  logic             loop_en,
  input  logic [IDX_W-1:0] song_len,
  input  logic [5:0]       rom_code,
  output logic [1:0]       song_sel,
  output logic [IDX_W-1:0] rom_addr,
  output logic [5:0]       tone_code,
  output logic             tone_gate,
  output logic             busy,
  output logic             song_done
);

  localparam logic [31:0] GapUnit  = 32'(GAP_CYCLES);
  localparam logic [31:0] SndUnit  = 32'(UNIT_CYCLES - GAP_CYCLES);
  localparam logic [1:0]  LastSong = 2'(NUM_SONGS - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StLoad, StGap, StSound, StPaused} state_e;

  state_e           state_q, state_d, ret_q, ret_d, run_state;
  logic [31:0]      timer_q, timer_d, run_timer;
  logic [IDX_W-1:0] addr_q, addr_d, run_addr;
  logic [1:0]       sel_q, sel_d;
  logic [5:0]       code_q, code_d, run_code;
  logic [2:0]       unit_q, unit_d, run_unit;
  logic             run_done, nav;
  logic [31:0]      gap_last, snd_last;

  function automatic logic [2:0] note_units(input logic [5:0] code);
    logic [2:0] u;
    if      (code < 6'd8)  u = 3'd2;
    else if (code < 6'd15) u = 3'd4;
    else if (code < 6'd22) u = 3'd1;
    else if (code < 6'd29) u = 3'd2;
    else if (code < 6'd36) u = 3'd4;
    else if (code < 6'd43) u = 3'd1;
    else if (code < 6'd50) u = 3'd2;
    else if (code < 6'd57) u = 3'd4;
    else                   u = 3'd1;
    return u;
  endfunction

  assign gap_last = 32'(unit_q) * GapUnit - 32'd1;
  assign snd_last = 32'(unit_q) * SndUnit - 32'd1;
  assign nav      = next ^ prev;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    code_d    = code_q;
    unit_d    = unit_q;
    song_done = 1'b0;
    run_state = state_q;
    run_timer = timer_q;
    run_addr  = addr_q;
    run_code  = code_q;
    run_unit  = unit_q;
    run_done  = 1'b0;

    // Uncontrolled progression of the playing states for this cycle.
    case (state_q)
      StAddr: begin
        if (addr_q >= song_len) begin
          run_done  = 1'b1;
          run_addr  = '0;
          run_state = loop_en ? StAddr : StIdle;
        end else begin
          run_state = StLoad;
        end
      end
      StLoad: begin
        run_code  = rom_code;
        run_unit  = note_units(rom_code);
        run_timer = '0;
        run_state = StGap;
      end
      StGap: begin
        if (timer_q == gap_last) begin
          run_timer = '0;
          run_state = StSound;
        end else begin
          run_timer = timer_q + 32'd1;
        end
      end
      StSound: begin
        if (timer_q == snd_last) begin
          run_timer = '0;
          run_addr  = addr_q + IDX_W'(1);
          run_state = StAddr;
        end else begin
          run_timer = timer_q + 32'd1;
        end
      end
      default: ;
    endcase

    if (stop) begin
      state_d = StIdle;
      addr_d  = '0;
      timer_d = '0;
    end else if (nav) begin
      if (next) sel_d = (sel_q == LastSong) ? 2'd0 : sel_q + 2'd1;
      else      sel_d = (sel_q == 2'd0) ? LastSong : sel_q - 2'd1;
      addr_d  = '0;
      timer_d = '0;
      state_d = (state_q == StIdle || state_q == StPaused) ? StIdle : StAddr;
    end else if (state_q == StPaused) begin
      if (play) state_d = ret_q;
    end else if (state_q == StIdle) begin
      if (play) state_d = StAddr;
    end else begin
      timer_d   = run_timer;
      addr_d    = run_addr;
      code_d    = run_code;
      unit_d    = run_unit;
      song_done = run_done;
      state_d   = run_state;
      // A pause still completes this cycle's work; resume picks up where it would have gone.
      if (pause && run_state != StIdle) begin
        ret_d   = run_state;
        state_d = StPaused;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
      timer_q <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      code_q  <= '0;
      unit_q  <= 3'd1;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      unit_q  <= unit_d;
    end
  end

  assign song_sel  = sel_q;
  assign rom_addr  = addr_q;
  assign tone_code = code_q;
  assign tone_gate = (state_q == StSound) && (code_q != 6'd0);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_music_play_ctrl.sv
// Bench for music_play_ctrl: a per-cycle expectation queue built from note durations, replayed
// against the DUT with a small song ROM model.
module tb_music_play_ctrl;

  localparam int unsigned U = 8;
  localparam int unsigned G = 2;
  localparam int EvNone = 0, EvStop = 1, EvNext = 2, EvPause = 3, EvBoth = 4, EvTrunc = 5;

  logic       clk = 1'b0, rst = 1'b0;
  logic       play = 1'b0, pause = 1'b0, stop = 1'b0, next = 1'b0, prev = 1'b0, loop_en = 1'b0;
  logic [7:0] song_len;
  logic [5:0] rom_code = 6'd0;
  logic [1:0] song_sel;
  logic [7:0] rom_addr;
  logic [5:0] tone_code;
  logic       tone_gate, busy, song_done;

  music_play_ctrl #(.UNIT_CYCLES(U), .GAP_CYCLES(G), .NUM_SONGS(3), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .next(next), .prev(prev),
    .loop_en(loop_en), .song_len(song_len), .rom_code(rom_code), .song_sel(song_sel),
    .rom_addr(rom_addr), .tone_code(tone_code), .tone_gate(tone_gate), .busy(busy),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Song ROM: song0 {8,15}, song1 {0,22}, song2 {57,36,50}.
  function automatic logic [5:0] rom_at(input logic [1:0] s, input logic [1:0] i);
    case ({s, i})
      4'b0000: return 6'd8;
      4'b0001: return 6'd15;
      4'b0100: return 6'd0;
      4'b0101: return 6'd22;
      4'b1000: return 6'd57;
      4'b1001: return 6'd36;
      4'b1010: return 6'd50;
      default: return 6'd0;
    endcase
  endfunction

  always_comb song_len = (song_sel == 2'd2) ? 8'd3 : 8'd2;
  always @(posedge clk) rom_code <= rom_at(song_sel, rom_addr[1:0]);

  typedef struct {
    logic       play, pause, stop, next, prev, loop_en;
    logic       gate, busy, done;
    logic [7:0] addr;
    logic [1:0] sel;
    logic [5:0] code;
  } rec_t;

  rec_t       q[$];
  rec_t       cur;
  logic       cur_valid = 1'b0;
  int         n_pass = 0, n_total = 0, cyc_n = 0, gate_cnt = 0, done_cnt = 0;
  string      scen = "reset";
  logic [7:0] m_addr = '0;
  logic [1:0] m_sel = '0;
  logic [5:0] m_code = '0;
  logic       s_play = 0, s_pause = 0, s_stop = 0, s_next = 0, s_prev = 0, s_loop = 0;
  bit         cut;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s/%s cyc=%0d got=%0h want=%0h", scen, name, cyc_n, act, exp);
    else
      n_pass++;
  endtask

  // Duration units: code 0..7 are 2 units, then blocks of seven codes cycle 4,1,2 units.
  function automatic int units(input logic [5:0] code);
    int k;
    k = (code == 6'd0) ? 0 : ((int'(code) - 1) / 7) % 3;
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  task automatic push(input logic gate, input logic bsy, input logic done);
    rec_t r;
    r.play = s_play; r.pause = s_pause; r.stop = s_stop; r.next = s_next; r.prev = s_prev;
    r.loop_en = s_loop; r.gate = gate; r.busy = bsy; r.done = done;
    r.addr = m_addr; r.sel = m_sel; r.code = m_code;
    q.push_back(r);
    s_play = 0; s_pause = 0; s_stop = 0; s_next = 0; s_prev = 0;
  endtask

  task automatic start();
    s_play = 1;
    push(0, 0, 0);
  endtask

  task automatic end_song();
    push(0, 1, 1);
    m_addr = '0;
  endtask

  // One note from its fetch cycle; an optional control event lands in cycle ev_idx of phase
  // ev_ph (1 = gap, 2 = sound).
  task automatic note(input logic [5:0] code, input int ev_ph, input int ev_idx,
                      input int ev_kind, input int hold, output bit aborted);
    int   u, n;
    logic g;
    aborted = 0;
    push(0, 1, 0);
    push(0, 1, 0);
    m_code = code;
    u = units(code);
    for (int ph = 1; ph <= 2; ph++) begin
      n = (ph == 1) ? u * G : u * (U - G);
      g = (ph == 2) && (code != 6'd0);
      for (int i = 0; i < n; i++) begin
        if (ph == ev_ph && i == ev_idx) begin
          case (ev_kind)
            EvStop: begin
              s_stop = 1; push(g, 1, 0); m_addr = '0; aborted = 1; return;
            end
            EvNext: begin
              s_next = 1; push(g, 1, 0);
              m_sel = (m_sel == 2'd2) ? 2'd0 : m_sel + 2'd1;
              m_addr = '0; aborted = 1; return;
            end
            EvPause: begin
              s_pause = 1; push(g, 1, 0);
              for (int h = 0; h < hold; h++) begin
                if (h == hold - 1) s_play = 1;
                push(0, 1, 0);
              end
            end
            EvBoth: begin
              s_next = 1; s_prev = 1; push(g, 1, 0);
            end
            default: begin
              aborted = 1; return;
            end
          endcase
        end else begin
          push(g, 1, 0);
        end
      end
    end
    m_addr = m_addr + 8'd1;
  endtask

  task automatic play_note(input logic [5:0] code);
    bit c;
    note(code, 0, 0, EvNone, 0, c);
  endtask

  task automatic run();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      cur = q.pop_front();
      play = cur.play; pause = cur.pause; stop = cur.stop;
      next = cur.next; prev = cur.prev; loop_en = cur.loop_en;
      cur_valid = 1'b1;
    end
    @(posedge clk); #1;
    cur_valid = 1'b0;
    play = 0; pause = 0; stop = 0; next = 0; prev = 0; loop_en = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gate"}, 32'(tone_gate), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(song_done), 0);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_sel"},  32'(song_sel), 0);
    chk({tag, "_code"}, 32'(tone_code), 0);
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      cyc_n++;
      chk("gate", 32'(tone_gate), 32'(cur.gate));
      chk("busy", 32'(busy), 32'(cur.busy));
      chk("done", 32'(song_done), 32'(cur.done));
      chk("addr", 32'(rom_addr), 32'(cur.addr));
      chk("sel",  32'(song_sel), 32'(cur.sel));
      chk("code", 32'(tone_code), 32'(cur.code));
      if (tone_gate === 1'b1) gate_cnt++;
      if (song_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset("rst0");
    #20 rst = 1'b0;

    scen = "basic";
    gate_cnt = 0; done_cnt = 0;
    start(); play_note(6'd8); play_note(6'd15); end_song(); push(0, 0, 0);
    run();
    chk("gate_cycles", gate_cnt, 30);
    chk("done_pulses", done_cnt, 1);

    scen = "pause";
    gate_cnt = 0;
    start(); note(6'd8, 2, 9, EvPause, 50, cut); play_note(6'd15); end_song(); push(0, 0, 0);
    run();
    chk("gate_cycles", gate_cnt, 30);

    scen = "loop_stop";
    done_cnt = 0;
    s_loop = 1;
    start(); play_note(6'd8); play_note(6'd15); end_song();
    note(6'd8, 1, 3, EvStop, 0, cut);
    s_loop = 0;
    push(0, 0, 0); push(0, 0, 0);
    run();
    chk("done_pulses", done_cnt, 1);

    scen = "select";
    done_cnt = 0;
    s_prev = 1; push(0, 0, 0); m_sel = 2'd2;
    push(0, 0, 0);
    start(); play_note(6'd57); note(6'd36, 2, 2, EvNext, 0, cut);
    play_note(6'd8); play_note(6'd15); end_song(); push(0, 0, 0);
    s_next = 1; s_prev = 1; push(0, 0, 0);
    s_next = 1; push(0, 0, 0); m_sel = 2'd1;
    push(0, 0, 0);
    start(); play_note(6'd0); note(6'd22, 1, 1, EvBoth, 0, cut); end_song(); push(0, 0, 0);
    run();
    chk("done_pulses", done_cnt, 2);

    scen = "async_rst";
    start(); play_note(6'd0); note(6'd22, 2, 4, EvTrunc, 0, cut);
    run();
    chk("gate_pre_rst", 32'(tone_gate), 1);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    m_addr = '0; m_sel = '0; m_code = '0;
    gate_cnt = 0; done_cnt = 0;
    start(); play_note(6'd8); play_note(6'd15); end_song(); push(0, 0, 0);
    run();
    chk("gate_cycles", gate_cnt, 30);
    chk("done_pulses", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
